// File: rtl/steer_pkg.sv
// steer_pkg: shared channel map, scheduler states and rider-weight defaults
package steer_pkg;
    localparam logic [2:0]  CH_LFT            = 3'd0;
    localparam logic [2:0]  CH_RGHT           = 3'd4;
    localparam logic [2:0]  CH_BATT           = 3'd5;
    localparam logic [12:0] MIN_RIDER_WT_DFLT = 13'h0200;
    localparam logic [12:0] HYST_DFLT         = 13'h0040;
    typedef enum logic [2:0] {IDLE, LFT, RGHT, BATT, UPD} sched_state_t;
endpackage

// File: rtl/load_cell_sched_if.sv
// load_cell_sched_if: A2D conversion handshake between the scheduler and the converter
interface load_cell_sched_if;
    logic        a2d_strt;
    logic [2:0]  a2d_chnl;
    logic        a2d_cnv_cmplt;
    logic [11:0] a2d_res;
    modport master (output a2d_strt, a2d_chnl, input a2d_cnv_cmplt, a2d_res);
    modport slave  (input a2d_strt, a2d_chnl, output a2d_cnv_cmplt, a2d_res);
endinterface

// File: rtl/steer_tmr.sv
// steer_tmr: saturating steering-qualification timer, clr_tmr wins over counting
module steer_tmr #(
    parameter int FULL_CYC = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_tmr,
    output logic tmr_full
);
    localparam int W = $clog2(FULL_CYC + 1);
    logic [W-1:0] cnt;
    assign tmr_full = cnt == W'(FULL_CYC);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else
            cnt <= clr_tmr ? '0 : tmr_full ? cnt : cnt + 1'b1;
endmodule

// File: rtl/load_cell_sched.sv
// load_cell_sched: periodic left/right/battery A2D rounds with hysteretic rider flags
module load_cell_sched
    import steer_pkg::*;
#(
    parameter int          PERIOD_CYC   = 1_048_576,
    parameter int          TMR_FULL_CYC = 65_000_000,
    parameter logic [12:0] MIN_RIDER_WT = MIN_RIDER_WT_DFLT,
    parameter logic [12:0] HYST         = HYST_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    load_cell_sched_if.master a2d,
    input  logic              clr_tmr,
    output logic [11:0]       lft_ld,
    output logic [11:0]       rght_ld,
    output logic [11:0]       batt,
    output logic              sum_gt_min,
    output logic              sum_lt_min,
    output logic              diff_gt_1_4,
    output logic              diff_gt_15_16,
    output logic              tmr_full,
    output logic              rnd_vld
);
    localparam int PW = $clog2(PERIOD_CYC);
    sched_state_t  state, nxt;
    logic [PW-1:0] per_cnt;
    logic          tick, cmplt, strt_nxt, upd_go;
    logic [2:0]    chnl_nxt;
    logic [12:0]   sum;
    logic [11:0]   diff;
    assign tick  = per_cnt == PW'(PERIOD_CYC - 1);
    assign cmplt = a2d.a2d_cnv_cmplt;
    assign sum   = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff  = lft_ld >= rght_ld ? lft_ld - rght_ld : rght_ld - lft_ld;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            per_cnt <= '0;
        else
            per_cnt <= tick ? '0 : per_cnt + 1'b1;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    // a tick outside IDLE is simply not looked at, so late rounds drop it
    always_comb begin
        nxt      = state;
        strt_nxt = 1'b0;
        chnl_nxt = CH_LFT;
        upd_go   = 1'b0;
        case (state)
            IDLE: if (tick) begin
                nxt      = LFT;
                strt_nxt = 1'b1;
            end
            LFT: if (cmplt) begin
                nxt      = RGHT;
                strt_nxt = 1'b1;
                chnl_nxt = CH_RGHT;
            end
            RGHT: if (cmplt) begin
                nxt      = BATT;
                strt_nxt = 1'b1;
                chnl_nxt = CH_BATT;
            end
            BATT: if (cmplt) begin
                nxt    = UPD;
                upd_go = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end
    // flags and rnd_vld are loaded together so they are coherent during UPD
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a2d.a2d_strt  <= 1'b0;
            a2d.a2d_chnl  <= CH_LFT;
            lft_ld        <= '0;
            rght_ld       <= '0;
            batt          <= '0;
            sum_gt_min    <= 1'b0;
            sum_lt_min    <= 1'b1;
            diff_gt_1_4   <= 1'b0;
            diff_gt_15_16 <= 1'b0;
            rnd_vld       <= 1'b0;
        end else begin
            a2d.a2d_strt <= strt_nxt;
            rnd_vld      <= upd_go;
            if (strt_nxt)
                a2d.a2d_chnl <= chnl_nxt;
            if (cmplt && state == LFT)
                lft_ld <= a2d.a2d_res;
            if (cmplt && state == RGHT)
                rght_ld <= a2d.a2d_res;
            if (cmplt && state == BATT)
                batt <= a2d.a2d_res;
            if (upd_go) begin
                sum_gt_min    <= sum > MIN_RIDER_WT + HYST;
                sum_lt_min    <= sum < MIN_RIDER_WT - HYST;
                diff_gt_1_4   <= {1'b0, diff} > (sum >> 2);
                diff_gt_15_16 <= {1'b0, diff} > sum - (sum >> 4);
            end
        end
    steer_tmr #(.FULL_CYC(TMR_FULL_CYC)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .clr_tmr  (clr_tmr),
        .tmr_full (tmr_full)
    );
endmodule
